xd_align: RTL and testbench
===========================

XD_ALIGN -- requirements
Module: xd_align

Interface
REQ-001 SHALL have parameter DW, default 16, FP16 word width.
REQ-002 SHALL have parameter H, default 24, number of heads (D table depth).
REQ-003 SHALL have parameter P, default 64, head dimension (x elements per head).
REQ-004 SHALL have parameter MUL_LAT, default 6, multiplier pipeline latency in cycles.
REQ-005 SHALL have parameter FIFO_DEPTH, default 32, xD holding depth (power of two).
REQ-006 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-007 SHALL have port rstn  input  1  reset, asynchronous, active-high (asserted at 1 despite the name).
REQ-008 SHALL have port clear_i  input  1  synchronous restart of index counters and FIFO.
REQ-009 SHALL have ports d_we_i input 1 / d_addr_i input clog2(H) / d_data_i input DW  D table write.
REQ-010 SHALL have ports x_valid_i input 1 / x_i input DW  x element stream, order p fastest, then h.
REQ-011 SHALL have ports ytmp_valid_i input 1 / ytmp_i input DW  y partial stream, same order as x.
REQ-012 SHALL have ports valid_o output 1 / ytmp_o output DW / xD_o output DW  aligned pair for y_out.
REQ-013 SHALL have port count_o  output clog2(FIFO_DEPTH)+1  FIFO occupancy.

Function
REQ-014 SHALL hold D[0..H-1] in registers; d_we_i writes d_data_i to D[d_addr_i] at the clock edge; d_addr_i >= H SHALL be ignored.
REQ-015 SHALL keep p_cnt and h_cnt, both 0 after reset; each x_valid_i cycle increments p_cnt; p_cnt = P-1 wraps to 0 and increments h_cnt; h_cnt = H-1 with p_cnt wrap returns to 0.
REQ-016 SHALL multiply x_i by D[h_cnt] as read in the accepting cycle; a same-cycle write to that entry SHALL NOT affect the product (old value used).
REQ-017 SHALL produce each product exactly MUL_LAT cycles after its x_valid_i, one product per accepted input, order preserved, back-to-back inputs allowed.
REQ-018 SHALL push each product into the FIFO in the cycle it leaves the multiplier.
REQ-019 SHALL pop on ytmp_valid_i when FIFO non-empty; one cycle later valid_o=1, xD_o=popped word, ytmp_o=registered ytmp_i.
REQ-020 SHALL treat ytmp_valid_i with FIFO empty (including same-cycle push into empty FIFO) as underflow: no pop, valid_o=0 next cycle, pushed word retained.
REQ-021 SHALL drop a push into a full FIFO without a same-cycle pop (overflow); push and pop together when full SHALL both succeed, count unchanged.
REQ-022 SHALL make count_o reflect occupancy registered after each edge; pointers wrap modulo FIFO_DEPTH.
REQ-023 SHALL on clear_i zero p_cnt, h_cnt, FIFO pointers and count, cancel in-flight multiplier valids, and force valid_o=0 next cycle; D table retained; clear_i dominates same-cycle x_valid_i/ytmp_valid_i.

Reset
REQ-024 SHALL on rstn=1 asynchronously zero p_cnt, h_cnt, D table, FIFO pointers, count_o, multiplier valid pipeline, valid_o, ytmp_o, xD_o.
REQ-025 SHALL discard all in-flight data when reset asserts mid-operation; first x after release is (h=0, p=0).

Configuration
REQ-026 SHALL with XD_ALIGN_ERR_FLAGS_EN defined add outputs ovf_o and udf_o (1 bit each), sticky-set on REQ-021 overflow and REQ-020 underflow, cleared by rstn or clear_i.
REQ-027 SHALL without XD_ALIGN_ERR_FLAGS_EN omit both ports and all flag logic; data behaviour identical.

Structure
REQ-028 SHALL place FP16 width constant, default H, P, MUL_LAT, FIFO_DEPTH in the shared mamba2 package.
REQ-029 SHALL instantiate one sub-module fp16_mul_wrapper (clk, valid_in, a, b, result, valid_out); FIFO and counters inline.

Verification
REQ-030 SHALL cover: D[3]=0x4000 (2.0), stream 4*P x with x=0x3C00 -> products for h=3 equal 0x4000, valid exactly MUL_LAT after input.
REQ-031 SHALL cover: H*P+1 consecutive x -> h_cnt wraps, last product uses D[0]; p/h ordering matches reference model.
REQ-032 SHALL cover: FIFO_DEPTH+1 products, no ytmp -> count_o=FIFO_DEPTH, last dropped, ovf_o=1 (macro on).
REQ-033 SHALL cover: ytmp_valid_i while empty -> valid_o=0, udf_o=1; later ytmp pops earliest product, ytmp_o = that ytmp_i.
REQ-034 SHALL cover: full FIFO with simultaneous push/pop -> count_o stays FIFO_DEPTH, no overflow; rstn pulse mid-stream -> all outputs 0, next x uses D[0].

Source files
------------

// File: rtl/mamba2_pkg.sv
// rtl/mamba2_pkg.sv - shared mamba2 constants and FP16 multiply helper
//
// Purpose : FP16 word width, default xD alignment geometry and the FP16 product
//           function used by the multiplier wrapper.
// Contents: FP16_W, DEF_H, DEF_P, DEF_MUL_LAT, DEF_FIFO_DEPTH, fp16_mul().
package mamba2_pkg;

    localparam int FP16_W         = 16;
    localparam int DEF_H          = 24;
    localparam int DEF_P          = 64;
    localparam int DEF_MUL_LAT    = 6;
    localparam int DEF_FIFO_DEPTH = 32;

    // IEEE binary16 multiply, round-to-nearest-even. Subnormal inputs and
    // results are flushed to signed zero; any NaN yields the canonical quiet NaN.
    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic               sgn;
        logic [4:0]         ea;
        logic [4:0]         eb;
        logic [9:0]         ma;
        logic [9:0]         mb;
        logic               a_nan;
        logic               b_nan;
        logic               a_inf;
        logic               b_inf;
        logic               a_zero;
        logic               b_zero;
        logic [21:0]        prod;
        logic signed [7:0]  exp_s;
        logic [10:0]        mant_r;
        logic               guard;
        logic               sticky;
        logic [15:0]        res;

        sgn    = a[15] ^ b[15];
        ea     = a[14:10];
        eb     = b[14:10];
        ma     = a[9:0];
        mb     = b[9:0];
        a_nan  = (ea == 5'h1F) && (ma != 10'd0);
        b_nan  = (eb == 5'h1F) && (mb != 10'd0);
        a_inf  = (ea == 5'h1F) && (ma == 10'd0);
        b_inf  = (eb == 5'h1F) && (mb == 10'd0);
        a_zero = (ea == 5'h00);
        b_zero = (eb == 5'h00);

        prod  = 22'({1'b1, ma}) * 22'({1'b1, mb});
        exp_s = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 8'sd15;

        // Product of two 1.xxx mantissas lies in [1,4); normalise to 1.xxx.
        if (prod[21]) begin
            mant_r = {1'b0, prod[20:11]};
            guard  = prod[10];
            sticky = |prod[9:0];
            exp_s  = exp_s + 8'sd1;
        end else begin
            mant_r = {1'b0, prod[19:10]};
            guard  = prod[9];
            sticky = |prod[8:0];
        end

        if (guard && (sticky || mant_r[0])) begin
            mant_r = mant_r + 11'd1;
        end
        // Rounding carried into the hidden bit: mantissa becomes 1.000.
        if (mant_r[10]) begin
            mant_r = 11'd0;
            exp_s  = exp_s + 8'sd1;
        end

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            res = 16'h7E00;
        end else if (a_inf || b_inf) begin
            res = {sgn, 5'h1F, 10'h000};
        end else if (a_zero || b_zero) begin
            res = {sgn, 15'h0000};
        end else if (exp_s >= 8'sd31) begin
            res = {sgn, 5'h1F, 10'h000};
        end else if (exp_s <= 8'sd0) begin
            res = {sgn, 15'h0000};
        end else begin
            res = {sgn, exp_s[4:0], mant_r[9:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/fp16_mul_wrapper.sv
// rtl/fp16_mul_wrapper.sv - fixed-latency pipelined FP16 multiplier
//
// Purpose : result = a * b, valid_out asserted exactly LAT cycles after valid_in.
// Ports   : clk, rst (async active-high), flush (sync drop of in-flight valids),
//           valid_in, a, b, result, valid_out.
module fp16_mul_wrapper
    import mamba2_pkg::*;
#(
    parameter int LAT = DEF_MUL_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [FP16_W-1:0] a,
    input  logic [FP16_W-1:0] b,
    output logic [FP16_W-1:0] result,
    output logic              valid_out
);

    logic [LAT-1:0]    r_vld;
    logic [FP16_W-1:0] r_res [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
        end else if (flush) begin
            r_vld <= '0;
        end else begin
            r_vld <= (r_vld << 1) | LAT'(valid_in);
        end
    end

    // Data stages carry no reset; only the valid chain qualifies them.
    always_ff @(posedge clk) begin
        r_res[0] <= fp16_mul(a, b);
        for (int i = 1; i < LAT; i++) begin
            r_res[i] <= r_res[i-1];
        end
    end

    assign result    = r_res[LAT-1];
    assign valid_out = r_vld[LAT-1];

endmodule

// File: rtl/xd_align.sv
// rtl/xd_align.sv - x*D[h] product generation and alignment with the y partial stream
//
// Purpose : Holds per-head D values, multiplies each streamed x by D[h], buffers
//           the products in a FIFO and pairs each with the matching ytmp word.
// Ports   : clk, rstn (async, active-high), clear_i (sync restart),
//           d_we_i/d_addr_i/d_data_i  D table write,
//           x_valid_i/x_i             x stream (p fastest, then h),
//           ytmp_valid_i/ytmp_i       y partial stream,
//           valid_o/ytmp_o/xD_o       aligned output pair,
//           count_o                   FIFO occupancy,
//           ovf_o/udf_o               sticky overflow/underflow flags
//                                     (only with XD_ALIGN_ERR_FLAGS_EN defined).
module xd_align
    import mamba2_pkg::*;
#(
    parameter int DW         = FP16_W,
    parameter int H          = DEF_H,
    parameter int P          = DEF_P,
    parameter int MUL_LAT    = DEF_MUL_LAT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        clear_i,
    input  logic                        d_we_i,
    input  logic [$clog2(H)-1:0]        d_addr_i,
    input  logic [DW-1:0]               d_data_i,
    input  logic                        x_valid_i,
    input  logic [DW-1:0]               x_i,
    input  logic                        ytmp_valid_i,
    input  logic [DW-1:0]               ytmp_i,
    output logic                        valid_o,
    output logic [DW-1:0]               ytmp_o,
    output logic [DW-1:0]               xD_o,
`ifdef XD_ALIGN_ERR_FLAGS_EN
    output logic                        ovf_o,
    output logic                        udf_o,
`endif
    output logic [$clog2(FIFO_DEPTH):0] count_o
);

    localparam int AW  = $clog2(H);
    localparam int PW  = (P > 1) ? $clog2(P) : 1;
    localparam int FAW = $clog2(FIFO_DEPTH);

    localparam logic [AW:0]   H_LIM    = (AW+1)'(H);
    localparam logic [AW-1:0] H_LAST   = AW'(H - 1);
    localparam logic [PW-1:0] P_LAST   = PW'(P - 1);
    localparam logic [FAW:0]  FULL_CNT = (FAW+1)'(FIFO_DEPTH);

    logic [DW-1:0]  r_d [H];
    logic [PW-1:0]  r_p_cnt;
    logic [AW-1:0]  r_h_cnt;
    logic [DW-1:0]  r_mem [FIFO_DEPTH];
    logic [FAW-1:0] r_wr_ptr;
    logic [FAW-1:0] r_rd_ptr;
    logic [FAW:0]   r_count;

    logic           w_x_acc;
    logic [DW-1:0]  w_d_sel;
    logic           w_mul_vld;
    logic [DW-1:0]  w_mul_res;
    logic           w_empty;
    logic           w_full;
    logic           w_pop;
    logic           w_push;

    // clear_i wins over any stream activity in the same cycle.
    assign w_x_acc = x_valid_i & ~clear_i;
    // Combinational read of the register: a same-cycle write lands after the edge.
    assign w_d_sel = r_d[r_h_cnt];

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int i = 0; i < H; i++) begin
                r_d[i] <= '0;
            end
        end else if (d_we_i && ({1'b0, d_addr_i} < H_LIM)) begin
            r_d[d_addr_i] <= d_data_i;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_p_cnt <= '0;
            r_h_cnt <= '0;
        end else if (clear_i) begin
            r_p_cnt <= '0;
            r_h_cnt <= '0;
        end else if (w_x_acc) begin
            if (r_p_cnt == P_LAST) begin
                r_p_cnt <= '0;
                r_h_cnt <= (r_h_cnt == H_LAST) ? '0 : r_h_cnt + 1'b1;
            end else begin
                r_p_cnt <= r_p_cnt + 1'b1;
            end
        end
    end

    fp16_mul_wrapper #(
        .LAT (MUL_LAT)
    ) u_mul (
        .clk       (clk),
        .rst       (rstn),
        .flush     (clear_i),
        .valid_in  (w_x_acc),
        .a         (x_i),
        .b         (w_d_sel),
        .result    (w_mul_res),
        .valid_out (w_mul_vld)
    );

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    // An empty FIFO refuses the pop even if a product arrives this cycle.
    assign w_pop   = ytmp_valid_i & ~w_empty & ~clear_i;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign w_push  = w_mul_vld & (~w_full | w_pop) & ~clear_i;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_mul_res;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            valid_o <= 1'b0;
            xD_o    <= '0;
            ytmp_o  <= '0;
        end else begin
            valid_o <= w_pop;
            if (w_pop) begin
                xD_o   <= r_mem[r_rd_ptr];
                ytmp_o <= ytmp_i;
            end
        end
    end

    assign count_o = r_count;

`ifdef XD_ALIGN_ERR_FLAGS_EN
    logic r_ovf;
    logic r_udf;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (clear_i) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_mul_vld && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
            if (ytmp_valid_i && w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign ovf_o = r_ovf;
    assign udf_o = r_udf;
`endif

endmodule

// File: tb/tb_xd_align.sv
// tb/tb_xd_align.sv - directed self-checking bench for xd_align
module tb_xd_align;
    import mamba2_pkg::*;

    localparam int L  = DEF_MUL_LAT;
    localparam int H  = DEF_H;
    localparam int P  = DEF_P;
    localparam int FD = DEF_FIFO_DEPTH;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        clear_i = 1'b0;
    logic        d_we_i = 1'b0;
    logic [4:0]  d_addr_i = '0;
    logic [15:0] d_data_i = '0;
    logic        x_valid_i = 1'b0;
    logic [15:0] x_i = '0;
    logic        ytmp_valid_i = 1'b0;
    logic [15:0] ytmp_i = '0;
    logic        valid_o;
    logic [15:0] ytmp_o;
    logic [15:0] xD_o;
    logic [5:0]  count_o;
`ifdef XD_ALIGN_ERR_FLAGS_EN
    logic        ovf_o;
    logic        udf_o;
`endif

    xd_align dut (
        .clk          (clk),
        .rstn         (rstn),
        .clear_i      (clear_i),
        .d_we_i       (d_we_i),
        .d_addr_i     (d_addr_i),
        .d_data_i     (d_data_i),
        .x_valid_i    (x_valid_i),
        .x_i          (x_i),
        .ytmp_valid_i (ytmp_valid_i),
        .ytmp_i       (ytmp_i),
        .valid_o      (valid_o),
        .ytmp_o       (ytmp_o),
        .xD_o         (xD_o),
`ifdef XD_ALIGN_ERR_FLAGS_EN
        .ovf_o        (ovf_o),
        .udf_o        (udf_o),
`endif
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] e;
    } vec_t;

    vec_t        vecs [14];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_d [H];
    int          m_p = 0;
    int          m_h = 0;
    logic [15:0] exp_q [$];
    int          mon_cnt = 0;
    int          tag_n = 0;
    int          max_cnt = 0;
    bit          mon_en = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic write_d(input int a, input logic [15:0] v);
        d_we_i   = 1'b1;
        d_addr_i = 5'(a);
        d_data_i = v;
        tick();
        d_we_i   = 1'b0;
        m_d[a]   = v;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        m_p = 0;
        m_h = 0;
        exp_q.delete();
        mon_cnt = 0;
        tag_n   = 0;
        max_cnt = 0;
    endtask

    task automatic adv_model();
        if (m_p == P - 1) begin
            m_p = 0;
            m_h = (m_h == H - 1) ? 0 : m_h + 1;
        end else begin
            m_p = m_p + 1;
        end
    endtask

    // x stream of nx words, pops on cycles [pop_start, pop_start+npop).
    // With alt set, odd x are 2.0 so the product doubles (exponent + 1).
    task automatic drive_stream(input int nx, input int pop_start, input int npop,
                                input bit alt, input int keep);
        int          total;
        int          pushed;
        logic [15:0] e;
        total  = ((nx > pop_start + npop) ? nx : pop_start + npop) + L + 3;
        pushed = 0;
        for (int n = 0; n < total; n++) begin
            x_valid_i = (n < nx);
            if (n < nx) begin
                x_i = (alt && (n % 2 == 1)) ? 16'h4000 : 16'h3C00;
                e   = m_d[m_h] + ((alt && (n % 2 == 1)) ? 16'h0400 : 16'h0000);
                if (pushed < keep) begin
                    exp_q.push_back(e);
                    pushed++;
                end
                adv_model();
            end
            ytmp_valid_i = (n >= pop_start) && (n < pop_start + npop);
            if (ytmp_valid_i) begin
                ytmp_i = 16'(32'h100 + tag_n);
                tag_n++;
            end
            tick();
        end
        x_valid_i    = 1'b0;
        ytmp_valid_i = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_unexpected_valid actual=1 expected=0");
                end else begin
                    chk("mon_xd", 32'(xD_o), 32'(exp_q.pop_front()));
                    chk("mon_ytmp", 32'(ytmp_o), 32'h100 + 32'(mon_cnt));
                    mon_cnt++;
                end
            end
        end
    end

    initial begin
        vecs[0]  = '{16'h3C00, 16'h4000, 16'h4000};
        vecs[1]  = '{16'h4000, 16'h4000, 16'h4400};
        vecs[2]  = '{16'h3E00, 16'h4000, 16'h4200};
        vecs[3]  = '{16'hBC00, 16'h4000, 16'hC000};
        vecs[4]  = '{16'h0000, 16'h4000, 16'h0000};
        vecs[5]  = '{16'h3C00, 16'h3555, 16'h3555};
        vecs[6]  = '{16'h7C00, 16'h4000, 16'h7C00};
        vecs[7]  = '{16'h7BFF, 16'h4000, 16'h7C00};
        vecs[8]  = '{16'h3E00, 16'h3E00, 16'h4080};
        vecs[9]  = '{16'h3C01, 16'h3C01, 16'h3C02};
        vecs[10] = '{16'h3C03, 16'h3E00, 16'h3E04};
        vecs[11] = '{16'h3C01, 16'h3E00, 16'h3E02};
        vecs[12] = '{16'h7E00, 16'h3C00, 16'h7E00};
        vecs[13] = '{16'h7C00, 16'h0000, 16'h7E00};
        for (int i = 0; i < H; i++) m_d[i] = 16'h0000;

        // Reset state
        tick();
        tick();
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_xd", 32'(xD_o), 32'd0);
        chk("rst_ytmp", 32'(ytmp_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
`ifdef XD_ALIGN_ERR_FLAGS_EN
        chk("rst_ovf", 32'(ovf_o), 32'd0);
        chk("rst_udf", 32'(udf_o), 32'd0);
`endif
        rstn = 1'b0;
        tick();

        // Multiplier vectors through D[0] and one FIFO slot
        for (int v = 0; v < 14; v++) begin
            d_we_i   = 1'b1;
            d_addr_i = 5'd0;
            d_data_i = vecs[v].b;
            clear_i  = 1'b1;
            tick();
            d_we_i    = 1'b0;
            clear_i   = 1'b0;
            x_valid_i = 1'b1;
            x_i       = vecs[v].a;
            tick();
            x_valid_i = 1'b0;
            repeat (L + 1) tick();
            chk($sformatf("vec%0d_count", v), 32'(count_o), 32'd1);
            ytmp_valid_i = 1'b1;
            ytmp_i       = 16'(16'hA000 + v);
            tick();
            ytmp_valid_i = 1'b0;
            chk($sformatf("vec%0d_valid", v), 32'(valid_o), 32'd1);
            chk($sformatf("vec%0d_xd", v), 32'(xD_o), 32'(vecs[v].e));
            chk($sformatf("vec%0d_ytmp", v), 32'(ytmp_o), 32'hA000 + 32'(v));
        end

        // D table with distinct normal values, D[3] = 2.0
        for (int h = 0; h < H; h++) write_d(h, 16'(32'h3C00 + (h << 6)));
        write_d(3, 16'h4000);

        // Exact latency and old-D-on-same-cycle-write
        do_clear();
        x_valid_i = 1'b1;
        x_i       = 16'h3C00;
        d_we_i    = 1'b1;
        d_addr_i  = 5'd0;
        d_data_i  = 16'h4800;
        tick();
        x_valid_i = 1'b0;
        d_we_i    = 1'b0;
        chk("lat_c1", 32'(count_o), 32'd0);
        for (int k = 2; k <= L; k++) begin
            tick();
            chk($sformatf("lat_c%0d", k), 32'(count_o), 32'd0);
        end
        tick();
        chk("lat_push", 32'(count_o), 32'd1);
        ytmp_valid_i = 1'b1;
        ytmp_i       = 16'h0777;
        tick();
        ytmp_valid_i = 1'b0;
        chk("oldd_valid", 32'(valid_o), 32'd1);
        chk("oldd_xd", 32'(xD_o), 32'h3C00);
        write_d(0, 16'h3C00);

        // 4*P x of 1.0 with a consumer trailing by L+1 cycles
        do_clear();
        mon_en = 1'b1;
        drive_stream(4 * P, L + 1, 4 * P, 1'b0, 1 << 30);
        chk("s4p_pops", 32'(mon_cnt), 32'(4 * P));
        chk("s4p_left", 32'(exp_q.size()), 32'd0);
        chk("s4p_maxcnt", 32'(max_cnt), 32'd1);

        // H*P+1 x: h wraps, last product back on D[0]
        do_clear();
        drive_stream(H * P + 1, L + 1, H * P + 1, 1'b1, 1 << 30);
        chk("wrap_pops", 32'(mon_cnt), 32'(H * P + 1));
        chk("wrap_left", 32'(exp_q.size()), 32'd0);

        // Overflow: FD+1 products, no consumer
        do_clear();
        drive_stream(FD + 1, 0, 0, 1'b1, FD);
        chk("ovf_count", 32'(count_o), 32'(FD));
`ifdef XD_ALIGN_ERR_FLAGS_EN
        chk("ovf_flag", 32'(ovf_o), 32'd1);
`endif
        drive_stream(0, 0, FD, 1'b0, 0);
        chk("ovf_drained", 32'(mon_cnt), 32'(FD));
        chk("ovf_count0", 32'(count_o), 32'd0);
`ifdef XD_ALIGN_ERR_FLAGS_EN
        chk("ovf_noudf", 32'(udf_o), 32'd0);
`endif

        // Full FIFO with simultaneous push and pop
        do_clear();
        drive_stream(FD + 1, FD + L, FD + 1, 1'b1, 1 << 30);
        chk("full_maxcnt", 32'(max_cnt), 32'(FD));
        chk("full_pops", 32'(mon_cnt), 32'(FD + 1));
        chk("full_count0", 32'(count_o), 32'd0);
`ifdef XD_ALIGN_ERR_FLAGS_EN
        chk("full_noovf", 32'(ovf_o), 32'd0);
`endif
        mon_en = 1'b0;

        // Underflow, then underflow coinciding with a push into empty FIFO
        do_clear();
        ytmp_valid_i = 1'b1;
        ytmp_i       = 16'h0BAD;
        tick();
        ytmp_valid_i = 1'b0;
        chk("udf_valid", 32'(valid_o), 32'd0);
        chk("udf_count", 32'(count_o), 32'd0);
`ifdef XD_ALIGN_ERR_FLAGS_EN
        chk("udf_flag", 32'(udf_o), 32'd1);
`endif
        x_valid_i = 1'b1;
        x_i       = 16'h3C00;
        tick();
        x_valid_i = 1'b0;
        repeat (L - 1) tick();
        ytmp_valid_i = 1'b1;
        tick();
        ytmp_valid_i = 1'b0;
        chk("udfp_valid", 32'(valid_o), 32'd0);
        chk("udfp_count", 32'(count_o), 32'd1);
        ytmp_valid_i = 1'b1;
        ytmp_i       = 16'h1234;
        tick();
        ytmp_valid_i = 1'b0;
        chk("udfp_pop_valid", 32'(valid_o), 32'd1);
        chk("udfp_pop_xd", 32'(xD_o), 32'(m_d[0]));
        chk("udfp_pop_ytmp", 32'(ytmp_o), 32'h1234);

        // Reset pulse mid-stream
        x_valid_i = 1'b1;
        x_i       = 16'h3C00;
        repeat (P + 5) tick();
        rstn = 1'b1;
        #1;
        chk("mrst_valid", 32'(valid_o), 32'd0);
        chk("mrst_xd", 32'(xD_o), 32'd0);
        chk("mrst_ytmp", 32'(ytmp_o), 32'd0);
        chk("mrst_count", 32'(count_o), 32'd0);
`ifdef XD_ALIGN_ERR_FLAGS_EN
        chk("mrst_udf", 32'(udf_o), 32'd0);
`endif
        tick();
        rstn      = 1'b0;
        x_valid_i = 1'b0;
        for (int i = 0; i < H; i++) m_d[i] = 16'h0000;
        repeat (L + 2) tick();
        chk("mrst_inflight", 32'(count_o), 32'd0);
        write_d(0, 16'h4400);
        write_d(1, 16'h4800);
        x_valid_i = 1'b1;
        x_i       = 16'h3C00;
        tick();
        x_valid_i = 1'b0;
        repeat (L + 1) tick();
        ytmp_valid_i = 1'b1;
        ytmp_i       = 16'h55AA;
        tick();
        ytmp_valid_i = 1'b0;
        chk("mrst_first_valid", 32'(valid_o), 32'd1);
        chk("mrst_first_xd", 32'(xD_o), 32'h4400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
